// File: rtl/wb_uart.sv
// Wishbone-attached UART: 8N1 transmitter and receiver, each behind its own byte FIFO.
// Define WB_UART_LOOPBACK_EN to add the CONTROL.loop bit that feeds TX back into RX internally.
module wb_uart #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_adr,
    input  logic [15:0] i_wb_dat,
    output logic [15:0] o_wb_dat,
    output logic        o_wb_ack,
    input  logic        i_cs,
    input  logic        i_rxd,
    output logic        o_txd
);

    localparam int              AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic        r_ack;
    logic [15:0] r_rdata;
    logic [15:0] r_divisor;
    logic        r_ovr;
    logic        r_ferr;
    logic [15:0] w_rdMux;
    logic [15:0] w_control;
    logic        w_req, w_rd, w_wr;
    logic [1:0]  w_adr;
    logic        w_unused;

    logic [7:0]  r_txMem [FIFO_DEPTH];
    logic [AW-1:0] r_txRd, r_txWr;
    logic [AW:0] r_txCount;
    logic        w_txFull, w_txEmpty, w_txPush, w_txPop, w_txIdle;

    logic [7:0]  r_rxMem [FIFO_DEPTH];
    logic [AW-1:0] r_rxRd, r_rxWr;
    logic [AW:0] r_rxCount;
    logic        w_rxFull, w_rxEmpty, w_rxPush, w_rxPop;

    state_t      r_txState, w_txNext;
    logic [15:0] r_txDiv, r_txCnt;
    logic [7:0]  r_txShift;
    logic [2:0]  r_txBit;
    logic        w_txBitEnd, w_txSerial;

    state_t      r_rxState, w_rxNext;
    logic [15:0] r_rxDiv, r_rxCnt;
    logic [15:0] w_rxHalf;
    logic [7:0]  r_rxShift;
    logic [2:0]  r_rxBit;
    logic        r_sync1, r_sync2, r_rxPrev;
    logic        w_rxSrc, w_rxIn, w_rxFall, w_divHalfZero, w_rxStopEnd;
    logic        w_ovrSet, w_ferrSet, w_stClr;

    assign w_unused = &{1'b0, i_wb_adr[15:2], i_wb_dat[15:8]};

    assign w_req = i_wb_cyc & i_wb_stb & i_cs & ~r_ack;
    assign w_rd  = w_req & ~i_wb_we;
    assign w_wr  = w_req & i_wb_we;
    assign w_adr = i_wb_adr[1:0];

    assign w_txFull  = (r_txCount == CNT_FULL);
    assign w_txEmpty = (r_txCount == '0);
    assign w_txPush  = w_wr & (w_adr == 2'd0) & ~w_txFull;
    assign w_txIdle  = (r_txState == S_IDLE) & w_txEmpty;

    assign w_rxFull  = (r_rxCount == CNT_FULL);
    assign w_rxEmpty = (r_rxCount == '0);
    assign w_rxPop   = w_rd & (w_adr == 2'd0) & ~w_rxEmpty;
    assign w_stClr   = w_rd & (w_adr == 2'd1);

`ifdef WB_UART_LOOPBACK_EN
    logic r_loop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_loop <= 1'b0;
        else if (w_wr && (w_adr == 2'd3))
            r_loop <= i_wb_dat[0];
    end

    assign w_control = {15'd0, r_loop};
    assign w_rxSrc   = r_loop ? w_txSerial : i_rxd;
    assign o_txd     = r_loop | w_txSerial;
`else
    assign w_control = 16'h0000;
    assign w_rxSrc   = i_rxd;
    assign o_txd     = w_txSerial;
`endif

    always_comb begin
        w_rdMux = 16'h0000;
        case (w_adr)
            2'd0: w_rdMux = w_rxEmpty ? 16'h0000 : {8'h00, r_rxMem[r_rxRd]};
            2'd1: w_rdMux = {11'd0, r_ferr, r_ovr, w_txIdle, w_txFull, ~w_rxEmpty};
            2'd2: w_rdMux = r_divisor;
            default: w_rdMux = w_control;
        endcase
    end

    // Read data is only non-zero during the ack cycle, so it is cleared whenever no read is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack     <= 1'b0;
            r_rdata   <= 16'h0000;
            r_divisor <= DIV_RESET;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_rd ? w_rdMux : 16'h0000;
            if (w_wr && (w_adr == 2'd2))
                r_divisor <= i_wb_dat;
            r_ovr  <= w_ovrSet  | (r_ovr  & ~w_stClr);
            r_ferr <= w_ferrSet | (r_ferr & ~w_stClr);
        end
    end

    assign o_wb_ack = r_ack;
    assign o_wb_dat = r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_txRd    <= '0;
            r_txWr    <= '0;
            r_txCount <= '0;
            r_rxRd    <= '0;
            r_rxWr    <= '0;
            r_rxCount <= '0;
        end else begin
            if (w_txPush) r_txWr <= r_txWr + PTR_ONE;
            if (w_txPop)  r_txRd <= r_txRd + PTR_ONE;
            case ({w_txPush, w_txPop})
                2'b10:   r_txCount <= r_txCount + CNT_ONE;
                2'b01:   r_txCount <= r_txCount - CNT_ONE;
                default: r_txCount <= r_txCount;
            endcase
            if (w_rxPush) r_rxWr <= r_rxWr + PTR_ONE;
            if (w_rxPop)  r_rxRd <= r_rxRd + PTR_ONE;
            case ({w_rxPush, w_rxPop})
                2'b10:   r_rxCount <= r_rxCount + CNT_ONE;
                2'b01:   r_rxCount <= r_rxCount - CNT_ONE;
                default: r_rxCount <= r_rxCount;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_txPush) r_txMem[r_txWr] <= i_wb_dat[7:0];
        if (w_rxPush) r_rxMem[r_rxWr] <= r_rxShift;
    end

    assign w_txBitEnd = (r_txCnt == r_txDiv);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_txState <= S_IDLE;
        else          r_txState <= w_txNext;
    end

    always_comb begin
        w_txNext   = r_txState;
        w_txPop    = 1'b0;
        w_txSerial = 1'b1;
        case (r_txState)
            S_IDLE: begin
                if (!w_txEmpty) begin
                    w_txNext = S_START;
                    w_txPop  = 1'b1;
                end
            end
            S_START: begin
                w_txSerial = 1'b0;
                if (w_txBitEnd) w_txNext = S_DATA;
            end
            S_DATA: begin
                w_txSerial = r_txShift[0];
                if (w_txBitEnd && (r_txBit == 3'd7)) w_txNext = S_STOP;
            end
            S_STOP: begin
                if (w_txBitEnd) begin
                    if (!w_txEmpty) begin
                        w_txNext = S_START;
                        w_txPop  = 1'b1;
                    end else begin
                        w_txNext = S_IDLE;
                    end
                end
            end
            default: w_txNext = S_IDLE;
        endcase
    end

    // The divisor is captured with each byte so a bus write only affects later frames.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_txDiv   <= 16'd0;
            r_txCnt   <= 16'd0;
            r_txShift <= 8'd0;
            r_txBit   <= 3'd0;
        end else if (w_txPop) begin
            r_txShift <= r_txMem[r_txRd];
            r_txDiv   <= r_divisor;
            r_txCnt   <= 16'd0;
            r_txBit   <= 3'd0;
        end else if (r_txState != S_IDLE) begin
            if (w_txBitEnd) begin
                r_txCnt <= 16'd0;
                if (r_txState == S_DATA) begin
                    r_txShift <= {1'b0, r_txShift[7:1]};
                    r_txBit   <= r_txBit + 3'd1;
                end
            end else begin
                r_txCnt <= r_txCnt + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= w_rxSrc;
            r_sync2  <= r_sync1;
            r_rxPrev <= r_sync2;
        end
    end

    assign w_rxIn        = r_sync2;
    assign w_rxFall      = r_rxPrev & ~w_rxIn;
    assign w_rxHalf      = {1'b0, r_rxDiv[15:1]};
    assign w_divHalfZero = (r_divisor[15:1] == 15'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rxState <= S_IDLE;
        else          r_rxState <= w_rxNext;
    end

    // The edge-detect cycle is the first cycle of the start bit; a zero half-period samples it right there.
    always_comb begin
        w_rxNext    = r_rxState;
        w_rxStopEnd = 1'b0;
        case (r_rxState)
            S_IDLE: begin
                if (w_rxFall) w_rxNext = w_divHalfZero ? S_DATA : S_START;
            end
            S_START: begin
                if (r_rxCnt == w_rxHalf) w_rxNext = w_rxIn ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if ((r_rxCnt == r_rxDiv) && (r_rxBit == 3'd7)) w_rxNext = S_STOP;
            end
            S_STOP: begin
                if (r_rxCnt == r_rxDiv) begin
                    w_rxStopEnd = 1'b1;
                    w_rxNext    = S_IDLE;
                end
            end
            default: w_rxNext = S_IDLE;
        endcase
    end

    assign w_rxPush  = w_rxStopEnd & w_rxIn & (~w_rxFull | w_rxPop);
    assign w_ovrSet  = w_rxStopEnd & w_rxIn & w_rxFull & ~w_rxPop;
    assign w_ferrSet = w_rxStopEnd & ~w_rxIn;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rxDiv   <= 16'd0;
            r_rxCnt   <= 16'd0;
            r_rxShift <= 8'd0;
            r_rxBit   <= 3'd0;
        end else begin
            case (r_rxState)
                S_IDLE: begin
                    r_rxDiv <= r_divisor;
                    r_rxCnt <= w_divHalfZero ? 16'd0 : 16'd1;
                    r_rxBit <= 3'd0;
                end
                S_START: begin
                    r_rxCnt <= (r_rxCnt == w_rxHalf) ? 16'd0 : r_rxCnt + 16'd1;
                end
                S_DATA: begin
                    if (r_rxCnt == r_rxDiv) begin
                        r_rxCnt   <= 16'd0;
                        r_rxShift <= {w_rxIn, r_rxShift[7:1]};
                        r_rxBit   <= r_rxBit + 3'd1;
                    end else begin
                        r_rxCnt <= r_rxCnt + 16'd1;
                    end
                end
                default: r_rxCnt <= r_rxCnt + 16'd1;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart: random bytes checked against a queue/flag model of the UART.
module tb_wb_uart;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, cs = 1'b0, rxd = 1'b1;
    logic [15:0] adr = 16'h0, wdat = 16'h0;
    logic [15:0] rdat;
    logic        ack, txd;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rxModel[$];
    logic [7:0]  txBytes[$];
    logic        ovrModel = 1'b0;
    logic        ferrModel = 1'b0;

    wb_uart #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_adr(adr), .i_wb_dat(wdat),
        .o_wb_dat(rdat), .o_wb_ack(ack), .i_cs(cs), .i_rxd(rxd), .o_txd(txd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wbCycle(input logic wr, input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        rd  = 16'hxxxx;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; cs = 1'b1; we = wr; adr = a; wdat = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                rd  = rdat;
                break;
            end
            lat++;
        end
        if (!got) checkOutput("ackTimeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; cs = 1'b0; we = 1'b0;
    endtask

    task automatic wbWrite(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        int lat;
        wbCycle(1'b1, a, d, dummy, lat);
    endtask

    task automatic wbRead(input logic [15:0] a, output logic [15:0] d);
        int lat;
        wbCycle(1'b0, a, 16'h0000, d, lat);
    endtask

    function automatic logic [15:0] expStatus(input logic txFull, input logic txIdle);
        return {11'd0, ferrModel, ovrModel, txIdle, txFull, rxModel.size() != 0};
    endfunction

    task automatic checkStatus(input string tag, input logic txFull, input logic txIdle);
        logic [15:0] d;
        wbRead(16'd1, d);
        checkOutput(tag, d, expStatus(txFull, txIdle));
        ovrModel  = 1'b0;
        ferrModel = 1'b0;
    endtask

    // Drives one serial frame on rxd and updates the receive model with its expected outcome.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int div);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (div + 1) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        repeat (2 * (div + 1) + 4) @(posedge clk);
        #1;
        if (!stopBit)                 ferrModel = 1'b1;
        else if (rxModel.size() < DEPTH) rxModel.push_back(data);
        else                          ovrModel = 1'b1;
    endtask

    task automatic captureTx(input string tag, input int div, input logic [7:0] exp);
        logic found, timingOk, expBit;
        logic [7:0] got;
        found = 1'b0;
        for (int i = 0; i < (div + 1) * 40 + 20; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, "Start"}, found, 1'b1);
        if (!found) return;
        timingOk = 1'b1;
        got = 8'h00;
        for (int b = 0; b < 10; b++) begin
            expBit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[b-1];
            for (int c = 0; c <= div; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (txd !== expBit) timingOk = 1'b0;
                if (b >= 1 && b <= 8 && c == div / 2) got[b-1] = txd;
            end
        end
        checkOutput({tag, "Timing"}, timingOk, 1'b1);
        checkOutput({tag, "Byte"}, got, exp);
    endtask

    initial begin
        logic [15:0] d, val;
        logic [7:0]  b;
        logic        allHigh, found;
        int          lat;

        $display("[TB] reset");
        #12;
        checkOutput("rstTxd", txd, 1'b1);
        checkOutput("rstAck", ack, 1'b0);
        checkOutput("rstRdat", rdat, 16'h0000);
        #20 rst_n = 1'b1;

        wbCycle(1'b0, 16'd2, 16'h0000, d, lat);
        checkOutput("divReset", d, 16'd433);
        checkOutput("ackLatency", lat, 1);
        @(negedge clk);
        checkOutput("rdatIdle", rdat, 16'h0000);
        checkStatus("statusReset", 1'b0, 1'b1);

        val = 16'($urandom);
        wbWrite(16'hA5F2, val);
        wbRead(16'h0002, d);
        checkOutput("divRW", d, val);
        wbWrite(16'd1, 16'hFFFF);
        checkStatus("statusWriteIgnored", 1'b0, 1'b1);

        wbWrite(16'd3, 16'h0001);
        wbRead(16'd3, d);
`ifdef WB_UART_LOOPBACK_EN
        checkOutput("controlRW", d, 16'h0001);
`else
        checkOutput("controlRW", d, 16'h0000);
`endif
        wbWrite(16'd3, 16'h0000);

        $display("[TB] transmit");
        wbWrite(16'd2, 16'd3);
        wbWrite(16'd0, 16'h00A5);
        captureTx("txA5", 3, 8'hA5);
        checkStatus("statusTxDone", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            wbWrite(16'd0, {8'($urandom), b});
            captureTx("txRand", 3, b);
        end
        wbWrite(16'd2, 16'd0);
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            wbWrite(16'd0, {8'h00, b});
            captureTx("txDiv0", 0, b);
        end

        $display("[TB] receive");
        wbWrite(16'd2, 16'd3);
        applyStimulus(8'h3C, 1'b1, 3);
        checkStatus("statusRx3C", 1'b0, 1'b1);
        wbRead(16'd0, d);
        checkOutput("rx3C", d, {8'h00, rxModel.pop_front()});
        checkStatus("statusRxEmpty", 1'b0, 1'b1);

        wbWrite(16'd2, 16'd0);
        for (int i = 0; i < 2; i++) applyStimulus(8'($urandom), 1'b1, 0);
        for (int i = 0; i < 2; i++) begin
            wbRead(16'd0, d);
            checkOutput("rxDiv0", d, {8'h00, rxModel.pop_front()});
        end

        $display("[TB] overrun");
        wbWrite(16'd2, 16'd3);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(8'($urandom), 1'b1, 3);
        checkStatus("statusOverrun", 1'b0, 1'b1);
        checkStatus("statusOverrunCleared", 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            wbRead(16'd0, d);
            checkOutput("rxFifoOrder", d, {8'h00, rxModel.pop_front()});
        end
        wbRead(16'd0, d);
        checkOutput("rxEmptyRead", d, 16'h0000);

        $display("[TB] framing and glitch");
        applyStimulus(8'($urandom), 1'b0, 3);
        checkStatus("statusFraming", 1'b0, 1'b1);
        @(posedge clk); #1;
        rxd = 1'b0;
        @(posedge clk); #1;
        rxd = 1'b1;
        repeat (60) @(posedge clk);
        checkStatus("statusGlitch", 1'b0, 1'b1);

        $display("[TB] transmit fifo full");
        wbWrite(16'd2, 16'd20);
        txBytes.delete();
        wbWrite(16'd0, 16'h00FF);
        for (int i = 0; i < DEPTH + 2; i++) begin
            b = 8'($urandom);
            wbWrite(16'd0, {8'h00, b});
            if (i < DEPTH) txBytes.push_back(b);
        end
        checkStatus("statusTxFull", 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("txFirstFrameHigh", found, 1'b1);
        for (int i = 0; i < DEPTH; i++) captureTx("txQueued", 20, txBytes[i]);
        checkStatus("statusTxDrained", 1'b0, 1'b1);

`ifdef WB_UART_LOOPBACK_EN
        $display("[TB] loopback");
        wbWrite(16'd2, 16'd3);
        wbWrite(16'd3, 16'h0001);
        wbWrite(16'd0, 16'h0055);
        allHigh = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) allHigh = 1'b0;
        end
        checkOutput("loopTxdHigh", allHigh, 1'b1);
        rxModel.push_back(8'h55);
        checkStatus("statusLoop", 1'b0, 1'b1);
        wbRead(16'd0, d);
        checkOutput("loopData", d, {8'h00, rxModel.pop_front()});
        wbWrite(16'd3, 16'h0000);
`endif

        $display("[TB] reset mid-frame");
        wbWrite(16'd2, 16'd3);
        wbWrite(16'd0, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("midFrameStart", found, 1'b1);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midFrameTxd", txd, 1'b1);
        rxModel.delete();
        ovrModel  = 1'b0;
        ferrModel = 1'b0;
        #20 rst_n = 1'b1;
        checkStatus("statusAfterReset", 1'b0, 1'b1);
        wbRead(16'd2, d);
        checkOutput("divAfterReset", d, 16'd433);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_uart.md
WB_UART -- requirements
Module: wb_uart

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: entries per TX and RX FIFO; power of 2, range 2..32.
REQ-002 SHALL have parameter DIV_RESET, default 16'd433: reset value of DIVISOR; bit period is DIVISOR+1 clk cycles.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; 0 resets the block, 1 runs it.
REQ-005 SHALL have port wb  if_wb.slave  -  Wishbone slave (cyc, stb, we, adr[15:0], 16-bit data in/out, ack).
REQ-006 SHALL have port cs  input  1  chip select from the external address decoder; qualifies cyc&stb.
REQ-007 SHALL have port rxd  input  1  serial receive line; asynchronous, idle high.
REQ-008 SHALL have port txd  output  1  serial transmit line; idle high.

Function
REQ-009 Register map by adr[1:0]: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CONTROL; adr[15:2] ignored.
REQ-010 Request = cyc & stb & cs & ~ack; ack registered: ack <= request; one-cycle pulse, one cycle after request; back-to-back requests acked every other cycle.
REQ-011 Register side effects (push, pop, flag clear, register write) happen once, in the cycle ack is asserted.
REQ-012 Read data registered, valid only while ack=1; data output SHALL be 16'h0000 when ack=0.
REQ-013 DATA write: push wdata[7:0] into TX FIFO; TX FIFO full -> byte dropped, still acked.
REQ-014 DATA read: return {8'h00, head of RX FIFO} and pop; RX FIFO empty -> return 16'h0000, no pop.
REQ-015 STATUS read: bit0 RX not empty, bit1 TX full, bit2 TX empty and transmitter idle, bit3 overrun (sticky), bit4 framing error (sticky), bits15:5 zero; read clears bits 3 and 4; writes ignored.
REQ-016 Sticky set and read-clear in the same cycle: set wins.
REQ-017 DIVISOR: 16-bit read/write; TX and RX each latch DIVISOR at frame start; write mid-frame affects next frame only.
REQ-018 TX FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE; each state holds txd for DIVISOR+1 cycles; leaves IDLE the cycle after TX FIFO non-empty, popping the byte; STOP goes directly to START if FIFO non-empty.
REQ-019 rxd passes through a 2-flop synchroniser before use.
REQ-020 RX FSM IDLE -> START -> DATA -> STOP -> IDLE; falling edge in IDLE starts counting; start bit sampled after DIVISOR/2 (truncated) cycles, high -> back to IDLE (glitch); data and stop sampled every DIVISOR+1 cycles thereafter.
REQ-021 Stop bit 0 -> byte discarded, framing error set; stop 1 and RX FIFO full -> byte discarded, overrun set; else byte pushed.
REQ-022 Simultaneous RX push and bus pop on a full RX FIFO: pop then push, no overrun.
REQ-023 DIVISOR=0 SHALL be legal: 1 clk per bit, RX mid-sample at 0 cycles.

Reset
REQ-024 reset=0 asynchronously forces: txd=1, ack=0, read data 0, both FIFOs empty, both FSMs IDLE, DIVISOR=DIV_RESET, CONTROL=0, sticky flags 0, synchroniser flops 1.
REQ-025 Reset mid-frame abandons the frame; txd returns to 1 immediately; no partial byte is pushed.

Configuration
REQ-026 Macro WB_UART_LOOPBACK_EN defined: CONTROL bit0 R/W "loop"; loop=1 routes internal TX serial output to RX input (ahead of synchroniser) and holds txd=1; other CONTROL bits read 0.
REQ-027 Macro undefined: CONTROL reads 16'h0000, writes ignored, no loopback mux.

Verification
REQ-028 Reset, read adr 2 -> ack one cycle later, data 16'd433; read adr 1 -> 16'h0004.
REQ-029 DIVISOR=3, write DATA 16'h00A5 -> txd low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles; STATUS bit2 then 1.
REQ-030 DIVISOR=3, drive rxd frame 0x3C -> STATUS bit0=1; DATA read returns 16'h003C; next STATUS bit0=0.
REQ-031 Receive FIFO_DEPTH+1 frames, no reads -> STATUS bit3=1, FIFO holds first 8 bytes in order; second STATUS read bit3=0.
REQ-032 Drive frame with stop bit 0 -> no push, STATUS bit4=1; 1-cycle-low glitch on idle rxd -> no frame.
REQ-033 WB_UART_LOOPBACK_EN defined, CONTROL=1, write DATA 16'h0055 -> txd stays 1, DATA read returns 16'h0055.
